// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-RAM write signals of the program loader.
// The master side is the byte source / controller, the slave side is the loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader that assembles little-endian 32-bit words,
// writes them to instruction RAM from BASE_ADDR and holds the core until complete.
module imem_loader #(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rst,
    imem_loader_if.slave bus
);
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                accept_c;
    logic [LEN_W-1:0]    len_val_c;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_lo_q    <= '0;
            remaining_q <= '0;
            byte_idx_q  <= '0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            remaining_q <= remaining_d;
            byte_idx_q  <= byte_idx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Next state, datapath updates, and outputs decoded from the next state
    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        remaining_d = remaining_q;
        byte_idx_d  = byte_idx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        accept_c    = bus.in_valid & in_ready_q;
        len_val_c   = {bus.in_data, len_lo_q};

        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept_c) begin
                    len_lo_d = bus.in_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept_c) begin
                    addr_d      = BASE_ADDR;
                    byte_idx_d  = '0;
                    remaining_d = len_val_c;
                    if ((len_val_c == '0) || (32'(len_val_c) > MAX_WORDS)) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    // Little-endian: first byte ends up in bits 7:0 after four shifts
                    wdata_d    = {bus.in_data, wdata_q[WORD_W-1:8]};
                    byte_idx_d = byte_idx_q + IDX_W'(1);
                    if (byte_idx_q == IDX_W'(3)) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d      = addr_q + ADDR_W'(4);
                remaining_d = remaining_q - LEN_W'(1);
                state_d     = (remaining_q == LEN_W'(1)) ? S_DONE : S_DATA;
            end
            S_DONE, S_ERROR: begin
                if (bus.start) state_d = S_LEN_LO;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
        mem_we_d   = (state_d == S_WRITE);
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERROR);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
endmodule
